// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
//
// Multi-cycle sequencer for the RV64I core datapath. Each instruction walks
// FETCH -> DECODE -> EXEC -> (MEM) -> (WB). The sequencer drives the IR/PC
// write enables, the ALU operand-B select, the memory request handshake and
// register-file write-back. Illegal opcodes and memory timeouts trap into an
// absorbing TRAP state that only reset leaves.
//
// Parameters:
//   INSTRSIZE    instruction width; opcode is instruction[6:0]
//   MEM_TIMEOUT  cycles to wait for mem_ready before faulting (1..255)
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous active-high reset
//   instruction   IR contents, valid from DECODE onward
//   mem_ready     memory completes the current request this cycle
//   branch_taken  comparator result, valid in EXEC
//   state         current state encoding (FETCH=0 .. TRAP=5)
//   mem_req       memory request
//   mem_we        write qualifier for mem_req
//   ir_write      load IR from memory read data
//   pc_write      PC write enable
//   pc_src        0 = PC+4, 1 = branch target
//   alu_src_imm   ALU operand B: 1 = immediate, 0 = rs2
//   reg_write     register-file write enable
//   wb_sel        write-back source: 0 = ALU, 1 = memory
//   illegal       sticky illegal-opcode trap flag
//   fault         sticky memory-timeout trap flag
//   instret       retired-instruction count
//
// Optional feature macro: MULTICYCLE_INSTRET_EN
//   defined   -> instret counts retirements (WB exit, STORE completion,
//                BRANCH EXEC exit), wrapping at 2^64
//   undefined -> instret is tied to zero and no counter flops exist
// ---------------------------------------------------------------------------
module multicycle_control #(
    parameter int INSTRSIZE   = 32,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [INSTRSIZE-1:0] instruction,
    input  logic                 mem_ready,
    input  logic                 branch_taken,
    output logic [2:0]           state,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 pc_src,
    output logic                 alu_src_imm,
    output logic                 reg_write,
    output logic                 wb_sel,
    output logic                 illegal,
    output logic                 fault,
    output logic [63:0]          instret
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [7:0] TIMEOUT_LIMIT = 8'(MEM_TIMEOUT);

    state_t     r_state;
    state_t     w_nextState;
    logic [7:0] r_waitCount;
    logic [7:0] w_waitCountNext;
    logic       r_illegal;
    logic       r_fault;
    logic       w_setIllegal;
    logic       w_setFault;

    logic       w_memReq;
    logic       w_memWe;
    logic       w_irWrite;
    logic       w_pcWrite;
    logic       w_pcSrc;
    logic       w_aluSrcImm;
    logic       w_regWrite;
    logic       w_wbSel;

    logic [6:0] w_opcode;
    logic       w_isLoad;
    logic       w_isStore;
    logic       w_isBranch;
    logic       w_isOpImm;
    logic       w_isOp;
    logic       w_isLegal;
    logic       w_unused;

    // Only the opcode field matters here; the rest of the word feeds the
    // immediate generator and register file elsewhere in the datapath.
    assign w_opcode   = instruction[6:0];
    assign w_unused   = ^instruction[INSTRSIZE-1:7];
    assign w_isLoad   = (w_opcode == OPC_LOAD);
    assign w_isStore  = (w_opcode == OPC_STORE);
    assign w_isBranch = (w_opcode == OPC_BRANCH);
    assign w_isOpImm  = (w_opcode == OPC_OPIMM);
    assign w_isOp     = (w_opcode == OPC_OP);
    assign w_isLegal  = w_isLoad | w_isStore | w_isBranch | w_isOpImm | w_isOp;

    // State register, wait counter and the two sticky trap flags. The trap
    // flags only ever get set here; reset is the sole way to clear them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_FETCH;
            r_waitCount <= '0;
            r_illegal   <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_state     <= w_nextState;
            r_waitCount <= w_waitCountNext;
            r_illegal   <= r_illegal | w_setIllegal;
            r_fault     <= r_fault | w_setFault;
        end
    end

    // Next-state and strobe decode. The wait counter defaults to zero so it
    // is cleared on every path except a genuine wait cycle in FETCH or MEM;
    // that covers both "clear on entry" and "clear on mem_ready". A ready in
    // the very cycle the limit is reached still completes the access.
    always_comb begin
        w_nextState     = r_state;
        w_waitCountNext = '0;
        w_setIllegal    = 1'b0;
        w_setFault      = 1'b0;
        w_memReq        = 1'b0;
        w_memWe         = 1'b0;
        w_irWrite       = 1'b0;
        w_pcWrite       = 1'b0;
        w_pcSrc         = 1'b0;
        w_aluSrcImm     = 1'b0;
        w_regWrite      = 1'b0;
        w_wbSel         = 1'b0;

        case (r_state)
            S_FETCH: begin
                w_memReq = 1'b1;
                if (mem_ready) begin
                    w_irWrite   = 1'b1;
                    w_pcWrite   = 1'b1;
                    w_nextState = S_DECODE;
                end else if (r_waitCount == TIMEOUT_LIMIT) begin
                    w_nextState = S_TRAP;
                    w_setFault  = 1'b1;
                end else begin
                    w_waitCountNext = r_waitCount + 8'd1;
                end
            end
            S_DECODE: begin
                if (w_isLegal) begin
                    w_nextState = S_EXEC;
                end else begin
                    w_nextState  = S_TRAP;
                    w_setIllegal = 1'b1;
                end
            end
            S_EXEC: begin
                w_aluSrcImm = w_isLoad | w_isStore | w_isOpImm;
                if (w_isBranch) begin
                    w_pcWrite   = branch_taken;
                    w_pcSrc     = 1'b1;
                    w_nextState = S_FETCH;
                end else if (w_isLoad | w_isStore) begin
                    w_nextState = S_MEM;
                end else if (w_isOp | w_isOpImm) begin
                    w_nextState = S_WB;
                end else begin
                    // IR changed under us after DECODE; treat as illegal.
                    w_nextState  = S_TRAP;
                    w_setIllegal = 1'b1;
                end
            end
            S_MEM: begin
                w_memReq = 1'b1;
                w_memWe  = w_isStore;
                if (mem_ready) begin
                    w_nextState = w_isStore ? S_FETCH : S_WB;
                end else if (r_waitCount == TIMEOUT_LIMIT) begin
                    w_nextState = S_TRAP;
                    w_setFault  = 1'b1;
                end else begin
                    w_waitCountNext = r_waitCount + 8'd1;
                end
            end
            S_WB: begin
                w_regWrite  = 1'b1;
                w_wbSel     = w_isLoad;
                w_nextState = S_FETCH;
            end
            S_TRAP: begin
                w_nextState = S_TRAP;
            end
            default: begin
                w_nextState = S_TRAP;
            end
        endcase
    end

    // Strobes are gated by rst so that a request pending at the moment of
    // reset disappears at once, and FETCH does not request while held.
    assign state       = r_state;
    assign mem_req     = w_memReq    & ~rst;
    assign mem_we      = w_memWe     & ~rst;
    assign ir_write    = w_irWrite   & ~rst;
    assign pc_write    = w_pcWrite   & ~rst;
    assign pc_src      = w_pcSrc     & ~rst;
    assign alu_src_imm = w_aluSrcImm & ~rst;
    assign reg_write   = w_regWrite  & ~rst;
    assign wb_sel      = w_wbSel     & ~rst;
    assign illegal     = r_illegal;
    assign fault       = r_fault;

`ifdef MULTICYCLE_INSTRET_EN
    logic [63:0] r_instret;
    logic        w_retire;

    // An instruction retires on the last cycle of its sequence: WB exit,
    // STORE completion in MEM, or BRANCH exit from EXEC. TRAP never retires.
    always_comb begin
        w_retire = (r_state == S_WB)
                 | ((r_state == S_MEM) & mem_ready & w_isStore)
                 | ((r_state == S_EXEC) & w_isBranch);
    end

    // Free-running retirement counter, wraps naturally at 2^64.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instret <= '0;
        end else if (w_retire) begin
            r_instret <= r_instret + 64'd1;
        end
    end

    assign instret = r_instret;
`else
    assign instret = '0;
`endif

endmodule
